// File: rtl/launcher_pkg.sv
// Shared types for the kernel launch sequencer: FSM state encoding and the
// completion record handed back to the host.
package launcher_pkg;

    // Width of a thread-count command word (matches the gpu DCR width).
    localparam int THREAD_BITS = 8;

    // Widest cycle count a completion record can carry; the top level
    // zero-extends its CYCLE_CNT_BITS counter into this field.
    localparam int RSP_CYCLES_MAX = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        CONFIG = 3'd2,
        RUN    = 3'd3,
        RESP   = 3'd4
    } state_t;

    typedef struct packed {
        logic [RSP_CYCLES_MAX-1:0] cycles;
        logic                      timeout;
    } launch_rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO used as the launch queue. The head
// entry is always visible on pop_data while empty is low, so the launcher
// can consume it in the same cycle it decides to pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             full_reg;
    logic             empty_reg;
    logic             push_ok;
    logic             pop_ok;

    // Overflow/underflow requests are dropped rather than corrupting state.
    assign push_ok = push && !full_reg;
    assign pop_ok  = pop && !empty_reg;

    // Occupancy after this cycle; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Storage: plain array without reset, written at the tail pointer.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; full/empty are
    // kept as flops so cmd_ready upstream comes straight from a register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == CNT_W'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    assign pop_data = mem[rd_ptr_reg];
    assign full     = full_reg;
    assign empty    = empty_reg;

endmodule

// File: rtl/kernel_launcher.sv
// Host-side launch sequencer for the gpu top. Queues thread-count launch
// requests and, per launch, resets the gpu, writes the DCR, holds start until
// done (or timeout) and returns a cycle-count completion record.
module kernel_launcher
    import launcher_pkg::*;
#(
    parameter int QUEUE_DEPTH    = 4,
    parameter int CYCLE_CNT_BITS = 16,
    parameter int TIMEOUT_CYCLES = 60000,
    parameter int RESET_CYCLES   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [THREAD_BITS-1:0]    cmd_thread_count,
    output logic                      gpu_reset,
    output logic                      gpu_dcr_we,
    output logic [THREAD_BITS-1:0]    gpu_dcr_data,
    output logic                      gpu_start,
    input  logic                      gpu_done,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [CYCLE_CNT_BITS-1:0] rsp_cycles,
    output logic                      rsp_timeout,
    output logic                      busy
);

    // Down-counter sized to hold RESET_CYCLES-1.
    localparam int RST_W = $clog2(RESET_CYCLES + 1);

    logic                      fifo_full;
    logic                      fifo_empty;
    logic [THREAD_BITS-1:0]    fifo_data;
    logic                      push_fire;
    logic                      pop_fire;

    state_t                    state_reg;
    logic [THREAD_BITS-1:0]    thread_reg;
    logic [RST_W-1:0]          rst_cnt_reg;
    logic [CYCLE_CNT_BITS-1:0] cycle_reg;
    logic [CYCLE_CNT_BITS-1:0] cycle_inc;
    logic                      timeout_hit;
    launch_rsp_t               rsp_reg;

    logic                      gpu_reset_reg;
    logic                      dcr_we_reg;
    logic [THREAD_BITS-1:0]    dcr_data_reg;
    logic                      start_reg;
    logic                      rsp_valid_reg;
    logic                      busy_reg;

    assign push_fire = cmd_valid && !fifo_full;
    // The FSM consumes the queue head only while idle.
    assign pop_fire  = (state_reg == IDLE) && !fifo_empty;

    sync_fifo #(
        .WIDTH (THREAD_BITS),
        .DEPTH (QUEUE_DEPTH)
    ) u_launch_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push_fire),
        .push_data (cmd_thread_count),
        .pop       (pop_fire),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Saturating increment of the RUN-cycle counter and the abort condition;
    // the count includes the cycle on which done (or timeout) is observed.
    always_comb begin
        cycle_inc   = (&cycle_reg) ? cycle_reg : cycle_reg + 1'b1;
        timeout_hit = (cycle_inc == CYCLE_CNT_BITS'(TIMEOUT_CYCLES));
    end

    // Launch sequencer; every output flop is loaded with the value belonging
    // to the state being entered, so outputs line up with state_reg.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            thread_reg    <= '0;
            rst_cnt_reg   <= '0;
            cycle_reg     <= '0;
            rsp_reg       <= '0;
            gpu_reset_reg <= 1'b1;
            dcr_we_reg    <= 1'b0;
            dcr_data_reg  <= '0;
            start_reg     <= 1'b0;
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        thread_reg <= fifo_data;
                        cycle_reg  <= '0;
                        busy_reg   <= 1'b1;
                        if (fifo_data == '0) begin
                            // Nothing to run: report an empty completion
                            // without ever releasing the gpu from reset.
                            state_reg       <= RESP;
                            rsp_reg.cycles  <= '0;
                            rsp_reg.timeout <= 1'b0;
                            rsp_valid_reg   <= 1'b1;
                        end else begin
                            state_reg   <= CLEAR;
                            rst_cnt_reg <= RST_W'(RESET_CYCLES - 1);
                        end
                    end else begin
                        busy_reg <= push_fire;
                    end
                end

                CLEAR: begin
                    if (rst_cnt_reg == '0) begin
                        state_reg     <= CONFIG;
                        gpu_reset_reg <= 1'b0;
                        dcr_we_reg    <= 1'b1;
                        dcr_data_reg  <= thread_reg;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg - 1'b1;
                    end
                end

                CONFIG: begin
                    state_reg    <= RUN;
                    dcr_we_reg   <= 1'b0;
                    dcr_data_reg <= '0;
                    start_reg    <= 1'b1;
                end

                RUN: begin
                    cycle_reg <= cycle_inc;
                    // done is checked first so it wins over a coincident timeout.
                    if (gpu_done || timeout_hit) begin
                        state_reg       <= RESP;
                        rsp_reg.cycles  <= RSP_CYCLES_MAX'(cycle_inc);
                        rsp_reg.timeout <= !gpu_done;
                        rsp_valid_reg   <= 1'b1;
                        start_reg       <= 1'b0;
                        gpu_reset_reg   <= 1'b1;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        busy_reg      <= !fifo_empty || push_fire;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    gpu_reset_reg <= 1'b1;
                    dcr_we_reg    <= 1'b0;
                    dcr_data_reg  <= '0;
                    start_reg     <= 1'b0;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Upper bits of the record are always zero when the counter is narrower.
    generate
        if (CYCLE_CNT_BITS < RSP_CYCLES_MAX) begin : g_rsp_pad
            logic unused_pad;
            assign unused_pad = ^rsp_reg.cycles[RSP_CYCLES_MAX-1:CYCLE_CNT_BITS];
        end
    endgenerate

    assign cmd_ready    = !fifo_full;
    assign gpu_reset    = gpu_reset_reg;
    assign gpu_dcr_we   = dcr_we_reg;
    assign gpu_dcr_data = dcr_data_reg;
    assign gpu_start    = start_reg;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_cycles   = rsp_reg.cycles[CYCLE_CNT_BITS-1:0];
    assign rsp_timeout  = rsp_reg.timeout;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_kernel_launcher.sv
// Bench for kernel_launcher: directed scenarios plus a randomized phase, all
// checked every cycle against a launch-level reference model and a simple
// gpu model that raises done a chosen number of RUN cycles after start.
module tb_kernel_launcher;

    localparam int QD = 4;
    localparam int CW = 16;
    localparam int TO = 100;
    localparam int RC = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    cmd_thread_count = '0;
    logic          gpu_reset;
    logic          gpu_dcr_we;
    logic [7:0]    gpu_dcr_data;
    logic          gpu_start;
    logic          gpu_done = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [CW-1:0] rsp_cycles;
    logic          rsp_timeout;
    logic          busy;

    kernel_launcher #(
        .QUEUE_DEPTH    (QD),
        .CYCLE_CNT_BITS (CW),
        .TIMEOUT_CYCLES (TO),
        .RESET_CYCLES   (RC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_thread_count (cmd_thread_count),
        .gpu_reset        (gpu_reset),
        .gpu_dcr_we       (gpu_dcr_we),
        .gpu_dcr_data     (gpu_dcr_data),
        .gpu_start        (gpu_start),
        .gpu_done         (gpu_done),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_cycles       (rsp_cycles),
        .rsp_timeout      (rsp_timeout),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int tc;
        int cycles;
        bit timeout;
    } exp_t;

    exp_t exp_q[$];       // responses still owed by the DUT, in order
    int   gpu_tc_q[$];    // thread counts the gpu should see on the DCR
    int   gpu_dly_q[$];   // matching done delays for the gpu model
    int   done_tc_q[$];   // thread counts of accepted responses, in order

    int   cmd_delay = 1;
    int   cur_delay = 0;
    int   run_seen = 0;
    int   start_cnt = 0;
    int   start_total = 0;
    bit   start_prev = 1'b0;
    int   push_cyc = 0;
    int   dcr_cyc = 0;
    int   first_start_cyc = 0;
    int   hs_cyc = 0;
    int   dcr_cnt = 0;
    int   last_rsp_cycles = 0;
    int   last_rsp_to = 0;
    bit   rand_done = 1'b0;

    // Launch-level rule: a zero-thread launch reports nothing; otherwise the
    // gpu finishes after dly RUN cycles unless the timeout comes strictly first.
    function automatic exp_t model_rsp(input int tc, input int dly);
        exp_t e;
        e.tc = tc;
        if (tc == 0) begin
            e.cycles  = 0;
            e.timeout = 1'b0;
        end else if (dly <= TO) begin
            e.cycles  = dly;
            e.timeout = 1'b0;
        end else begin
            e.cycles  = TO;
            e.timeout = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Per-cycle compare process plus the gpu behavioural model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", busy, (exp_q.size() != 0));

            if (cmd_valid && cmd_ready) begin
                exp_t e;
                e = model_rsp(int'(cmd_thread_count), cmd_delay);
                exp_q.push_back(e);
                if (cmd_thread_count != 0) begin
                    gpu_tc_q.push_back(int'(cmd_thread_count));
                    gpu_dly_q.push_back(cmd_delay);
                end
                push_cyc = cyc;
                $display("cycle %0d: push tc=%0d delay=%0d", cyc, cmd_thread_count, cmd_delay);
            end

            if (gpu_dcr_we) begin
                chk("dcr_reset_low", gpu_reset, 0);
                chk("dcr_no_start", gpu_start, 0);
                if (gpu_tc_q.size() == 0) begin
                    fail_now("dcr_unexpected");
                end else begin
                    chk("dcr_data", gpu_dcr_data, gpu_tc_q.pop_front());
                    cur_delay = gpu_dly_q.pop_front();
                end
                run_seen  = 0;
                start_cnt = 0;
                dcr_cyc   = cyc;
                dcr_cnt++;
            end

            if (gpu_start) begin
                chk("start_reset_low", gpu_reset, 0);
                if (!start_prev) first_start_cyc = cyc;
                start_cnt++;
                start_total++;
            end
            start_prev = gpu_start;

            if (rsp_valid) begin
                chk("rsp_reset_high", gpu_reset, 1);
                chk("rsp_no_start", gpu_start, 0);
                if (exp_q.size() == 0) begin
                    fail_now("rsp_unexpected");
                end else begin
                    exp_t e;
                    e = exp_q[0];
                    chk("rsp_cycles", rsp_cycles, e.cycles);
                    chk("rsp_timeout", rsp_timeout, e.timeout);
                    chk("rsp_vs_start_cycles", rsp_cycles, start_cnt);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        done_tc_q.push_back(e.tc);
                        hs_cyc          = cyc;
                        last_rsp_cycles = int'(rsp_cycles);
                        last_rsp_to     = int'(rsp_timeout);
                        start_cnt       = 0;
                        $display("cycle %0d: rsp tc=%0d cycles=%0d timeout=%0d", cyc, e.tc, rsp_cycles, rsp_timeout);
                    end
                end
            end

            // gpu model: done is noise whenever it must be ignored, and is
            // raised (sticky) on the RUN cycle numbered cur_delay.
            if (gpu_reset) begin
                run_seen = 0;
                gpu_done = ($urandom_range(0, 3) == 0);
            end else if (gpu_start) begin
                run_seen++;
                gpu_done = (run_seen >= cur_delay);
            end else begin
                gpu_done = ($urandom_range(0, 1) == 0);
            end
        end
    end

    task automatic push_cmd(input int tc, input int dly);
        bit ok;
        ok = 1'b0;
        cmd_valid        = 1'b1;
        cmd_thread_count = 8'(tc);
        cmd_delay        = dly;
        for (int w = 0; w < 3000; w++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("push_wait_expired");
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < bound; w++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !cmd_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("idle_wait_expired");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int bound);
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < bound; w++) begin
            @(negedge clk);
            if (gpu_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("start_wait_expired");
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gpu_reset"}, gpu_reset, 1);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_dcr_we"}, gpu_dcr_we, 0);
        chk({tag, "_dcr_data"}, gpu_dcr_data, 0);
        chk({tag, "_start"}, gpu_start, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_cycles"}, rsp_cycles, 0);
        chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int pc;
        int dc;
        int st;
        int h1;
        int order [6];

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: single launch, done 20 RUN cycles after start.
        push_cmd(8, 20);
        pc = push_cyc;
        wait_idle(500);
        chk("t1_dcr_latency", dcr_cyc - pc, 1 + RC + 1);
        chk("t1_start_latency", first_start_cyc - pc, 1 + RC + 2);
        chk("t1_cycles", last_rsp_cycles, 20);
        chk("t1_timeout", last_rsp_to, 0);

        // 3: zero threads never touch the gpu.
        dc = dcr_cnt;
        st = start_total;
        push_cmd(0, 5);
        pc = push_cyc;
        wait_idle(100);
        chk("t3_rsp_latency", hs_cyc - pc, 2);
        chk("t3_cycles", last_rsp_cycles, 0);
        chk("t3_no_dcr", dcr_cnt, dc);
        chk("t3_no_start", start_total, st);

        // 4: timeout, and the done/timeout tie where done wins.
        push_cmd(3, 1000);
        wait_idle(500);
        chk("t4_to_cycles", last_rsp_cycles, TO);
        chk("t4_to_flag", last_rsp_to, 1);
        push_cmd(5, TO);
        wait_idle(500);
        chk("t4_tie_cycles", last_rsp_cycles, TO);
        chk("t4_tie_flag", last_rsp_to, 0);
        push_cmd(6, TO + 1);
        wait_idle(500);
        chk("t4_late_flag", last_rsp_to, 1);

        // 2: fill the queue while a launch is running.
        done_tc_q.delete();
        push_cmd(9, 60);
        wait_start(100);
        push_cmd(8, 5);
        push_cmd(4, 7);
        push_cmd(12, 9);
        push_cmd(1, 11);
        @(negedge clk);
        chk("t2_queue_full", cmd_ready, 0);
        @(posedge clk);
        #1;
        push_cmd(2, 13);
        wait_idle(2000);
        order[0] = 9; order[1] = 8; order[2] = 4;
        order[3] = 12; order[4] = 1; order[5] = 2;
        chk("t2_rsp_count", done_tc_q.size(), 6);
        for (int i = 0; i < 6 && i < done_tc_q.size(); i++) begin
            chk("t2_rsp_order", done_tc_q[i], order[i]);
        end

        // 5: response back-pressure holds the record and the next launch.
        rsp_ready = 1'b0;
        push_cmd(5, 10);
        push_cmd(6, 4);
        begin
            bit ok;
            ok = 1'b0;
            for (int w = 0; w < 200; w++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) fail_now("t5_rsp_wait_expired");
        end
        repeat (10) begin
            @(negedge clk);
            chk("t5_hold_valid", rsp_valid, 1);
            chk("t5_hold_cycles", rsp_cycles, 10);
            chk("t5_no_next_dcr", gpu_dcr_we, 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_idle_after_ready", rsp_valid, 0);
        h1 = hs_cyc;
        wait_idle(300);
        chk("t5_next_dcr_latency", dcr_cyc - h1, 1 + RC + 1);

        // 6: reset in the middle of a run with two entries queued.
        push_cmd(7, 500);
        push_cmd(3, 5);
        push_cmd(4, 5);
        wait_start(100);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        exp_q.delete();
        gpu_tc_q.delete();
        gpu_dly_q.delete();
        start_cnt  = 0;
        run_seen   = 0;
        start_prev = 1'b0;
        gpu_done   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_busy_after", busy, 0);
        chk("t6_ready_after", cmd_ready, 1);
        chk("t6_no_rsp", rsp_valid, 0);

        // 7: randomized traffic with random back-pressure.
        rand_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 25; n++) begin
                    int tc;
                    tc = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
                    push_cmd(tc, int'($urandom_range(1, 130)));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        wait_idle(10000);
        chk("t7_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
